addition_control_unit: RTL and testbench

//  Sequencer for the FP adder datapath; the consumer of stage1's exp_diff and the driver of its mux selects.

---
 rtl/addition_pkg.sv | 18 +
 rtl/addition_control_unit_if.sv | 35 +++
 rtl/exp_diff_abs.sv | 16 +
 rtl/addition_control_unit.sv | 112 +++++++++++
 tb/tb_addition_control_unit.sv | 125 ++++++++++++
 5 files changed

// File: rtl/addition_pkg.sv
// Widths and FSM encoding shared by the FP adder control unit and datapath stages 1-4.
package addition_pkg;

    localparam int EXPO_W    = 8;
    localparam int MENT_W    = 23;
    localparam int SHIFT_W   = 5;
    localparam int MAX_SHIFT = MENT_W + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMPARE = 3'd1,
        ALIGN   = 3'd2,
        ADD     = 3'd3,
        NORM    = 3'd4,
        DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/addition_control_unit_if.sv
// Handshake and datapath-control bundle between the adder sequencer (slave) and its requester/datapath (master).
interface addition_control_unit_if
    import addition_pkg::*;
#(
    parameter int EXPO_WIDTH = EXPO_W
);
    logic                  start_in;
    logic [EXPO_WIDTH:0]   exp_diff_in;
    logic                  norm_done_in;
    logic                  busy_out;
    logic                  mux1_sel_out;
    logic                  mux2_sel_out;
    logic                  mux3_sel_out;
    logic                  shift_load_out;
    logic                  shift_en_out;
    logic                  bypass_out;
    logic                  add_en_out;
    logic                  norm_en_out;
    logic                  done_out;

    modport slave (
        input  start_in, exp_diff_in, norm_done_in,
        output busy_out, mux1_sel_out, mux2_sel_out, mux3_sel_out,
               shift_load_out, shift_en_out, bypass_out,
               add_en_out, norm_en_out, done_out
    );

    modport master (
        output start_in, exp_diff_in, norm_done_in,
        input  busy_out, mux1_sel_out, mux2_sel_out, mux3_sel_out,
               shift_load_out, shift_en_out, bypass_out,
               add_en_out, norm_en_out, done_out
    );

endinterface

// File: rtl/exp_diff_abs.sv
// Splits a two's-complement exponent difference into sign and unsigned magnitude.
module exp_diff_abs
    import addition_pkg::*;
#(
    parameter int WIDTH = EXPO_W + 1
) (
    input  logic [WIDTH-1:0] diff_i,
    output logic             sign_o,
    output logic [WIDTH-1:0] mag_o
);

    assign sign_o = diff_i[WIDTH-1];
    // The most negative input maps to 2^(WIDTH-1), which still fits as unsigned.
    assign mag_o  = sign_o ? (~diff_i + WIDTH'(1)) : diff_i;

endmodule

// File: rtl/addition_control_unit.sv
// Sequencer for the FP adder: operand selection, stepwise alignment, add, normalize and a done pulse.
module addition_control_unit
    import addition_pkg::*;
#(
    parameter int EXPO_WIDTH  = EXPO_W,
    parameter int MENT_WIDTH  = MENT_W,
    parameter int SHIFT_WIDTH = SHIFT_W
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    addition_control_unit_if.slave  bus
);

    localparam logic [EXPO_WIDTH:0] MAX_SHIFT_V = (EXPO_WIDTH + 1)'(MENT_WIDTH + 1);

    state_e                 state_q, state_d;
    logic [SHIFT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   sel_q, sel_d;
    logic                   bypass_q, bypass_d;

    logic                   diff_sign;
    logic [EXPO_WIDTH:0]    diff_mag;

    exp_diff_abs #(
        .WIDTH (EXPO_WIDTH + 1)
    ) u_exp_diff_abs (
        .diff_i (bus.exp_diff_in),
        .sign_o (diff_sign),
        .mag_o  (diff_mag)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            bypass_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            bypass_q <= bypass_d;
        end
    end

    // NOTE: every next-state signal gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        bypass_d = bypass_q;

        unique case (state_q)
            IDLE: begin
                // Capture the decision on the accepting edge so it is visible throughout COMPARE.
                if (bus.start_in) begin
                    state_d = COMPARE;
                    sel_d   = ~diff_sign;
                    if (diff_mag > MAX_SHIFT_V) begin
                        bypass_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        bypass_d = 1'b0;
                        cnt_d    = diff_mag[SHIFT_WIDTH-1:0];
                    end
                end
            end
            COMPARE: begin
                state_d = (cnt_q != '0) ? ALIGN : ADD;
            end
            ALIGN: begin
                cnt_d = cnt_q - SHIFT_WIDTH'(1);
                if (cnt_q <= SHIFT_WIDTH'(1)) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                state_d = NORM;
            end
            NORM: begin
                if (bus.norm_done_in) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d  = IDLE;
                sel_d    = 1'b0;
                bypass_d = 1'b0;
                cnt_d    = '0;
            end
            default: begin
                state_d  = IDLE;
                sel_d    = 1'b0;
                bypass_d = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    assign bus.busy_out       = (state_q != IDLE);
    assign bus.mux1_sel_out   = sel_q;
    assign bus.mux2_sel_out   = sel_q;
    assign bus.mux3_sel_out   = sel_q;
    assign bus.shift_load_out = (state_q == COMPARE);
    assign bus.shift_en_out   = (state_q == ALIGN);
    assign bus.bypass_out     = bypass_q;
    assign bus.add_en_out     = (state_q == ADD);
    assign bus.norm_en_out    = (state_q == NORM);
    assign bus.done_out       = (state_q == DONE);

endmodule

// File: tb/tb_addition_control_unit.sv
// Directed-vector bench for addition_control_unit: per-operation cycle accounting against hand-computed timings.
module tb_addition_control_unit;

    logic clk_in = 1'b0;
    logic rst_n_in;
    int   checks = 0;
    int   errors = 0;

    addition_control_unit_if bus_if ();

    addition_control_unit dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus_if)
    );

    always #5 clk_in = ~clk_in;

    logic [9:0] outs;
    assign outs = {bus_if.busy_out, bus_if.mux1_sel_out, bus_if.mux2_sel_out, bus_if.mux3_sel_out,
                   bus_if.shift_load_out, bus_if.shift_en_out, bus_if.bypass_out,
                   bus_if.add_en_out, bus_if.norm_en_out, bus_if.done_out};

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Runs one operation from the current (post-negedge) point; cycle 1 is the cycle after the accepting edge.
    task automatic run_op(input string tag, input logic [8:0] diff, input int m, input bit hold,
                          input bit spurious, input bit exp_sel, input bit exp_bypass,
                          input int exp_shifts, input int exp_add, input int exp_done);
        int shifts = 0, adds = 0, add_c = 0, norms = 0, loads = 0, load_c = 0, done_c = 0;
        int sel_bad = 0, byp_bad = 0, busy_bad = 0;
        bus_if.exp_diff_in = diff;
        bus_if.start_in    = 1'b1;
        @(posedge clk_in);
        for (int c = 1; c <= 60 && done_c == 0; c++) begin
            @(negedge clk_in);
            if (c == 1 && !hold) bus_if.start_in = 1'b0;
            if (!bus_if.busy_out) busy_bad++;
            if ({bus_if.mux1_sel_out, bus_if.mux2_sel_out, bus_if.mux3_sel_out} != {3{exp_sel}}) sel_bad++;
            if (bus_if.bypass_out != exp_bypass) byp_bad++;
            if (bus_if.shift_load_out) begin loads++; load_c = c; end
            if (bus_if.shift_en_out) shifts++;
            if (bus_if.add_en_out) begin adds++; add_c = c; end
            if (bus_if.norm_en_out) norms++;
            if (bus_if.done_out) done_c = c;
            bus_if.norm_done_in = bus_if.norm_en_out && (norms >= m);
            if (spurious && bus_if.shift_en_out && shifts == 2) bus_if.norm_done_in = 1'b1;
        end
        check({tag, " done_cycle"}, done_c, exp_done);
        check({tag, " shift_en_cycles"}, shifts, exp_shifts);
        check({tag, " add_en_cycle"}, add_c, exp_add);
        check({tag, " add_en_count"}, adds, 1);
        check({tag, " norm_en_cycles"}, norms, m);
        check({tag, " shift_load_cycle"}, load_c, 1);
        check({tag, " shift_load_count"}, loads, 1);
        check({tag, " sel_wrong_cycles"}, sel_bad, 0);
        check({tag, " bypass_wrong_cycles"}, byp_bad, 0);
        check({tag, " busy_low_cycles"}, busy_bad, 0);
        @(negedge clk_in);
        check({tag, " idle_outputs"}, int'(outs), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in            = 1'b0;
        bus_if.start_in     = 1'b0;
        bus_if.exp_diff_in  = '0;
        bus_if.norm_done_in = 1'b0;
        #1;
        check("reset_outputs", int'(outs), 0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;

        //      tag        diff     m  hold spur sel byp shifts add done
        run_op("pos3",    9'h003,  1, 0,   0,   1,  0,  3,     5,  7);
        run_op("neg5",    9'h1FB,  1, 0,   0,   0,  0,  5,     7,  9);
        run_op("zero",    9'h000,  1, 0,   0,   1,  0,  0,     2,  4);
        run_op("pos30",   9'h01E,  1, 0,   0,   1,  1,  0,     2,  4);
        run_op("neg256",  9'h100,  1, 0,   0,   0,  1,  0,     2,  4);
        run_op("pos24",   9'h018,  1, 0,   0,   1,  0,  24,    26, 28);
        run_op("pos25",   9'h019,  1, 0,   0,   1,  1,  0,     2,  4);
        run_op("neg24",   9'h1E8,  2, 0,   0,   0,  0,  24,    26, 29);

        // Reset abandoned in the 4th ALIGN cycle (cycle 5).
        bus_if.exp_diff_in = 9'h014;
        bus_if.start_in    = 1'b1;
        @(posedge clk_in);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_in);
            bus_if.start_in = 1'b0;
        end
        check("rst_mid shift_en_before", int'(bus_if.shift_en_out), 1);
        rst_n_in = 1'b0;
        #1;
        check("rst_mid outputs_async", int'(outs), 0);
        @(posedge clk_in);
        #1;
        check("rst_mid outputs_held", int'(outs), 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        run_op("after_rst", 9'h003, 1, 0, 0, 1, 0, 3, 5, 7);

        // start held high across two back-to-back operations, spurious norm_done during ALIGN.
        run_op("held_a",  9'h002,  4, 1,   1,   1,  0,  2,     4,  9);
        run_op("held_b",  9'h1FE,  4, 1,   1,   0,  0,  2,     4,  9);
        bus_if.start_in = 1'b0;
        @(negedge clk_in);
        check("held_end idle", int'(bus_if.busy_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
